// File: rtl/data_sched_pkg.sv
// Shared types for the data-side memory scheduler.
// Holds the FSM encoding, Blowfish modes and request tags.
package data_sched_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_W_POP  = 4'd1,
        S_W_ENC  = 4'd2,
        S_W_WAIT = 4'd3,
        S_W_MEM  = 4'd4,
        S_R_POP  = 4'd5,
        S_R_MEM  = 4'd6,
        S_R_DATA = 4'd7,
        S_R_DEC  = 4'd8,
        S_R_WAIT = 4'd9,
        S_R_HOLD = 4'd10
    } sched_state_t;

    localparam logic BF_ENCRYPT = 1'b0;
    localparam logic BF_DECRYPT = 1'b1;

    localparam logic REQ_STORE = 1'b0;
    localparam logic REQ_LOAD  = 1'b1;

endpackage

// File: rtl/req_order_queue.sv
// One-bit circular FIFO recording store/load program order.
// Extra pointer MSB distinguishes full from empty.
module req_order_queue #(
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic head,
    output logic empty,
    output logic full,
    output logic overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [DEPTH-1:0] slots;
    logic             do_pop;
    logic             accept;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = slots[rd_ptr[AW-1:0]];

    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot a full-queue push needs.
    assign accept   = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;

    // Pointer and slot storage update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            slots  <= '0;
        end else begin
            if (accept) begin
                slots[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/data_mem_scheduler.sv
// Serialises queued stores/loads through one Blowfish engine
// and the data memory, strictly in program order.
module data_mem_scheduler
    import data_sched_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 64,
    parameter int ORDER_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MWR_fifo_wr_en,
    input  logic              MRR_fifo_wr_en,
    input  logic              mwr_fifo_empty,
    input  logic [DATA_W-1:0] mwr_fifo_dout,
    input  logic [ADDR_W-1:0] mwr_addr_fifo_dout,
    output logic              mwr_fifo_rd_en,
    input  logic              mrr_fifo_empty,
    input  logic [ADDR_W-1:0] mrr_fifo_dout,
    output logic              mrr_fifo_rd_en,
    output logic              bf_start,
    output logic              bf_mode,
    output logic [DATA_W-1:0] bf_din,
    input  logic              bf_busy,
    input  logic              bf_done,
    input  logic [DATA_W-1:0] bf_dout,
    output logic              dmem_en,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              data_mem_decrypt_done,
    output logic [DATA_W-1:0] rd_data,
    input  logic              decrypt_ack,
    output logic              sched_busy,
    output logic              order_err
);

    sched_state_t state_q;
    sched_state_t state_d;

    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] addr_q;

    logic q_push;
    logic q_push_data;
    logic q_pop;
    logic q_head;
    logic q_empty;
    logic q_full;
    logic q_overflow;
    logic both_wr;

    assign both_wr     = MWR_fifo_wr_en && MRR_fifo_wr_en;
    assign q_push      = MWR_fifo_wr_en || MRR_fifo_wr_en;
    // A simultaneous store+load snoop is recorded as the store only.
    assign q_push_data = MWR_fifo_wr_en ? REQ_STORE : REQ_LOAD;

    req_order_queue #(
        .DEPTH (ORDER_DEPTH)
    ) u_order_q (
        .clk       (clk),
        .reset     (reset),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .head      (q_head),
        .empty     (q_empty),
        .full      (q_full),
        .overflow  (q_overflow)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, grant and handshake pulses.
    always_comb begin
        state_d        = state_q;
        mwr_fifo_rd_en = 1'b0;
        mrr_fifo_rd_en = 1'b0;
        bf_start       = 1'b0;
        q_pop          = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!q_empty) begin
                    if (q_head == REQ_STORE) begin
                        if (!mwr_fifo_empty) begin
                            mwr_fifo_rd_en = 1'b1;
                            q_pop          = 1'b1;
                            state_d        = S_W_POP;
                        end
                    end else if (!mrr_fifo_empty) begin
                        mrr_fifo_rd_en = 1'b1;
                        q_pop          = 1'b1;
                        state_d        = S_R_POP;
                    end
                end
            end
            S_W_POP:  state_d = S_W_ENC;
            S_W_ENC: begin
                if (!bf_busy) begin
                    bf_start = 1'b1;
                    state_d  = S_W_WAIT;
                end
            end
            S_W_WAIT: if (bf_done) state_d = S_W_MEM;
            S_W_MEM:  state_d = S_IDLE;
            S_R_POP:  state_d = S_R_MEM;
            S_R_MEM:  state_d = S_R_DATA;
            S_R_DATA: state_d = S_R_DEC;
            S_R_DEC: begin
                if (!bf_busy) begin
                    bf_start = 1'b1;
                    state_d  = S_R_WAIT;
                end
            end
            S_R_WAIT: if (bf_done) state_d = S_R_HOLD;
            S_R_HOLD: if (decrypt_ack) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath captures for address, block and load result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            addr_q  <= '0;
            rd_data <= '0;
        end else begin
            unique case (state_q)
                S_W_POP: begin
                    data_q <= mwr_fifo_dout;
                    addr_q <= mwr_addr_fifo_dout;
                end
                S_W_WAIT: if (bf_done) data_q <= bf_dout;
                S_R_POP:  addr_q <= mrr_fifo_dout;
                S_R_DATA: data_q <= dmem_rdata;
                S_R_WAIT: if (bf_done) rd_data <= bf_dout;
                default: ;
            endcase
        end
    end

    // Sticky protocol error: dual snoop or push into a full queue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            order_err <= 1'b0;
        end else if (both_wr || q_overflow) begin
            order_err <= 1'b1;
        end
    end

    assign bf_mode = (state_q == S_R_DEC || state_q == S_R_WAIT)
                   ? BF_DECRYPT : BF_ENCRYPT;
    assign bf_din  = data_q;

    assign dmem_en    = (state_q == S_W_MEM) || (state_q == S_R_MEM);
    assign dmem_we    = (state_q == S_W_MEM);
    assign dmem_addr  = addr_q;
    assign dmem_wdata = data_q;

    assign data_mem_decrypt_done = (state_q == S_R_HOLD);
    assign sched_busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_scheduler.sv
// Directed bench for data_mem_scheduler with FIFO, memory and
// 3-cycle Blowfish models; expectations kept in scoreboard queues.
module tb_data_mem_scheduler;

    localparam int AW = 10;
    localparam int DW = 64;
    localparam logic [63:0] KEY = 64'hA5A5_5A5A_0F0F_F0F0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wreq_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          MWR_fifo_wr_en;
    logic          MRR_fifo_wr_en;
    logic          mwr_fifo_empty = 1'b1;
    logic [DW-1:0] mwr_fifo_dout = '0;
    logic [AW-1:0] mwr_addr_fifo_dout = '0;
    logic          mwr_fifo_rd_en;
    logic          mrr_fifo_empty = 1'b1;
    logic [AW-1:0] mrr_fifo_dout = '0;
    logic          mrr_fifo_rd_en;
    logic          bf_start;
    logic          bf_mode;
    logic [DW-1:0] bf_din;
    logic          bf_busy;
    logic          bf_done;
    logic [DW-1:0] bf_dout = '0;
    logic          dmem_en;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata = '0;
    logic          data_mem_decrypt_done;
    logic [DW-1:0] rd_data;
    logic          decrypt_ack;
    logic          sched_busy;
    logic          order_err;

    data_mem_scheduler #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .ORDER_DEPTH (16)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .MWR_fifo_wr_en        (MWR_fifo_wr_en),
        .MRR_fifo_wr_en        (MRR_fifo_wr_en),
        .mwr_fifo_empty        (mwr_fifo_empty),
        .mwr_fifo_dout         (mwr_fifo_dout),
        .mwr_addr_fifo_dout    (mwr_addr_fifo_dout),
        .mwr_fifo_rd_en        (mwr_fifo_rd_en),
        .mrr_fifo_empty        (mrr_fifo_empty),
        .mrr_fifo_dout         (mrr_fifo_dout),
        .mrr_fifo_rd_en        (mrr_fifo_rd_en),
        .bf_start              (bf_start),
        .bf_mode               (bf_mode),
        .bf_din                (bf_din),
        .bf_busy               (bf_busy),
        .bf_done               (bf_done),
        .bf_dout               (bf_dout),
        .dmem_en               (dmem_en),
        .dmem_we               (dmem_we),
        .dmem_addr             (dmem_addr),
        .dmem_wdata            (dmem_wdata),
        .dmem_rdata            (dmem_rdata),
        .data_mem_decrypt_done (data_mem_decrypt_done),
        .rd_data               (rd_data),
        .decrypt_ack           (decrypt_ack),
        .sched_busy            (sched_busy),
        .order_err             (order_err)
    );

    function automatic logic [63:0] enc(input logic [63:0] x);
        return {x[55:0], x[63:56]} ^ KEY;
    endfunction

    function automatic logic [63:0] dec(input logic [63:0] y);
        logic [63:0] t;
        t = y ^ KEY;
        return {t[7:0], t[63:8]};
    endfunction

    // Stimulus staging and model controls
    logic [AW-1:0] st_waddr;
    logic [DW-1:0] st_wdata;
    logic [AW-1:0] st_raddr;
    logic          snoop_only;
    logic          force_busy;
    logic          stray_done;

    // FIFO models: dout valid the cycle after rd_en, empty lags a write
    wreq_t         mwr_q[$];
    logic [AW-1:0] mrr_q[$];

    always @(posedge clk) begin
        if (mwr_fifo_rd_en && mwr_q.size() > 0) begin
            mwr_fifo_dout      <= mwr_q[0].data;
            mwr_addr_fifo_dout <= mwr_q[0].addr;
            mwr_q.delete(0);
        end
        if (MWR_fifo_wr_en && !snoop_only)
            mwr_q.push_back('{st_waddr, st_wdata});
        mwr_fifo_empty <= (mwr_q.size() == 0);
    end

    always @(posedge clk) begin
        if (mrr_fifo_rd_en && mrr_q.size() > 0) begin
            mrr_fifo_dout <= mrr_q[0];
            mrr_q.delete(0);
        end
        if (MRR_fifo_wr_en && !snoop_only)
            mrr_q.push_back(st_raddr);
        mrr_fifo_empty <= (mrr_q.size() == 0);
    end

    // Memory model with 1-cycle read latency
    bit [63:0] mem [bit [9:0]];

    always @(posedge clk) begin
        if (dmem_en) begin
            if (dmem_we) mem[dmem_addr] = dmem_wdata;
            else         dmem_rdata <= mem[dmem_addr];
        end
    end

    // Blowfish model: 3-cycle latency, not reset by the scheduler
    logic          eng_busy = 1'b0;
    logic          eng_done = 1'b0;
    logic          eng_mode = 1'b0;
    logic [DW-1:0] eng_in = '0;
    int            eng_cnt = 0;

    assign bf_busy = eng_busy | force_busy;
    assign bf_done = eng_done | stray_done;

    always @(posedge clk) begin
        eng_done <= 1'b0;
        if (bf_start && !eng_busy) begin
            eng_busy <= 1'b1;
            eng_cnt  <= 3;
            eng_in   <= bf_din;
            eng_mode <= bf_mode;
        end else if (eng_busy) begin
            if (eng_cnt == 1) begin
                eng_busy <= 1'b0;
                eng_done <= 1'b1;
                bf_dout  <= eng_mode ? dec(eng_in) : enc(eng_in);
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    // Output monitor: logs memory traffic and counts pulses
    bit            acc_log[$];
    logic [AW-1:0] w_addr_log[$];
    logic [DW-1:0] w_data_log[$];
    int            n_start = 0;
    int            n_mwr_rd = 0;
    int            n_done_rise = 0;
    logic          done_prev = 1'b0;

    always @(posedge clk) begin
        if (dmem_en) begin
            acc_log.push_back(dmem_we);
            if (dmem_we) begin
                w_addr_log.push_back(dmem_addr);
                w_data_log.push_back(dmem_wdata);
            end
        end
        if (bf_start) n_start <= n_start + 1;
        if (mwr_fifo_rd_en) n_mwr_rd <= n_mwr_rd + 1;
        if (data_mem_decrypt_done && !done_prev)
            n_done_rise <= n_done_rise + 1;
        done_prev <= data_mem_decrypt_done;
    end

    // Scoreboard
    wreq_t         exp_w[$];
    logic [DW-1:0] exp_rd[$];
    bit            exp_acc[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        st_waddr       = a;
        st_wdata       = d;
        MWR_fifo_wr_en = 1'b1;
        @(negedge clk);
        MWR_fifo_wr_en = 1'b0;
    endtask

    task automatic push_load(input logic [AW-1:0] a);
        @(negedge clk);
        st_raddr       = a;
        MRR_fifo_wr_en = 1'b1;
        @(negedge clk);
        MRR_fifo_wr_en = 1'b0;
    endtask

    task automatic wait_writes(input int n, input string tag);
        int i = 0;
        while (w_data_log.size() < n && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 64'(w_data_log.size()), 64'(n));
    endtask

    task automatic wait_done(input string tag);
        int i = 0;
        while (!data_mem_decrypt_done && i < 200) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 64'(data_mem_decrypt_done), 64'd1);
    endtask

    task automatic ack();
        @(negedge clk);
        decrypt_ack = 1'b1;
        @(negedge clk);
        decrypt_ack = 1'b0;
    endtask

    localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] DA = 64'h1111_2222_3333_4444;
    localparam logic [63:0] DB = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] DC = 64'h5A5A_0000_FFFF_1234;

    initial begin
        wreq_t         e;
        logic [DW-1:0] r;
        int            b_start;
        int            b_mwr;
        int            b_done;
        int            i;

        reset          = 1'b0;
        MWR_fifo_wr_en = 1'b0;
        MRR_fifo_wr_en = 1'b0;
        decrypt_ack    = 1'b0;
        st_waddr       = '0;
        st_wdata       = '0;
        st_raddr       = '0;
        snoop_only     = 1'b0;
        force_busy     = 1'b0;
        stray_done     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(sched_busy), 64'd0);
        chk("rst_err", 64'(order_err), 64'd0);
        chk("rst_done", 64'(data_mem_decrypt_done), 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_dmem_en", 64'(dmem_en), 64'd0);
        chk("rst_bf_start", 64'(bf_start), 64'd0);
        chk("rst_q_empty", 64'(dut.u_order_q.empty), 64'd1);
        reset = 1'b1;
        @(negedge clk);

        // Single store
        b_start = n_start;
        b_mwr   = n_mwr_rd;
        push_store(10'h005, D0);
        exp_w.push_back('{10'h005, enc(D0)});
        exp_acc.push_back(1'b1);
        wait_writes(1, "st1_write_seen");
        e = exp_w.pop_front();
        chk("st1_addr", 64'(w_addr_log[0]), 64'(e.addr));
        chk("st1_data", w_data_log[0], e.data);
        chk("st1_mwr_rd_pulses", 64'(n_mwr_rd - b_mwr), 64'd1);
        chk("st1_bf_starts", 64'(n_start - b_start), 64'd1);
        chk("st1_busy_after", 64'(sched_busy), 64'd0);

        // Single load of the ciphertext just stored
        push_load(10'h005);
        exp_rd.push_back(D0);
        exp_acc.push_back(1'b0);
        wait_done("ld1_done");
        r = exp_rd.pop_front();
        chk("ld1_rd_data", rd_data, r);
        repeat (5) @(negedge clk);
        chk("ld1_done_held", 64'(data_mem_decrypt_done), 64'd1);
        ack();
        chk("ld1_done_fall", 64'(data_mem_decrypt_done), 64'd0);
        chk("ld1_idle", 64'(sched_busy), 64'd0);

        // Program ordering W R W R to one address
        push_store(10'h010, DA);
        exp_w.push_back('{10'h010, enc(DA)});
        exp_acc.push_back(1'b1);
        push_load(10'h010);
        exp_rd.push_back(DA);
        exp_acc.push_back(1'b0);
        push_store(10'h010, DB);
        exp_w.push_back('{10'h010, enc(DB)});
        exp_acc.push_back(1'b1);
        push_load(10'h010);
        exp_rd.push_back(DB);
        exp_acc.push_back(1'b0);
        wait_done("ord_ld_a_done");
        r = exp_rd.pop_front();
        chk("ord_ld_a", rd_data, r);
        ack();
        wait_done("ord_ld_b_done");
        r = exp_rd.pop_front();
        chk("ord_ld_b", rd_data, r);
        ack();
        wait_writes(3, "ord_writes");
        for (int k = 1; k < 3; k++) begin
            e = exp_w.pop_front();
            chk("ord_w_addr", 64'(w_addr_log[k]), 64'(e.addr));
            chk("ord_w_data", w_data_log[k], e.data);
        end
        chk("ord_acc_count", 64'(acc_log.size()), 64'(exp_acc.size()));
        for (int k = 0; k < 6; k++) begin
            chk("ord_acc_kind", 64'(acc_log[k]), 64'(exp_acc[k]));
        end

        // Engine busy holds off bf_start
        force_busy = 1'b1;
        b_start    = n_start;
        push_store(10'h020, DC);
        exp_w.push_back('{10'h020, enc(DC)});
        repeat (8) @(negedge clk);
        chk("busy_start_withheld", 64'(n_start - b_start), 64'd0);
        chk("busy_sched_busy", 64'(sched_busy), 64'd1);
        force_busy = 1'b0;
        wait_writes(4, "busy_write_seen");
        chk("busy_one_start", 64'(n_start - b_start), 64'd1);
        e = exp_w.pop_front();
        chk("busy_w_data", w_data_log[3], e.data);

        // Dual snoop: store recorded, error flagged and sticky
        snoop_only = 1'b1;
        @(negedge clk);
        MWR_fifo_wr_en = 1'b1;
        MRR_fifo_wr_en = 1'b1;
        @(negedge clk);
        MWR_fifo_wr_en = 1'b0;
        MRR_fifo_wr_en = 1'b0;
        chk("dual_err", 64'(order_err), 64'd1);
        chk("dual_q_nonempty", 64'(dut.u_order_q.empty), 64'd0);
        chk("dual_head_store", 64'(dut.u_order_q.head), 64'd0);
        repeat (3) @(negedge clk);
        chk("dual_err_sticky", 64'(order_err), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("dual_err_cleared", 64'(order_err), 64'd0);
        reset = 1'b1;

        // Overflow: 17 pushes into a 16-deep queue
        @(negedge clk);
        MRR_fifo_wr_en = 1'b1;
        repeat (16) @(negedge clk);
        chk("ovf_full_at_16", 64'(dut.u_order_q.full), 64'd1);
        chk("ovf_no_err_at_16", 64'(order_err), 64'd0);
        @(negedge clk);
        MRR_fifo_wr_en = 1'b0;
        chk("ovf_err", 64'(order_err), 64'd1);
        chk("ovf_still_full", 64'(dut.u_order_q.full), 64'd1);
        repeat (4) @(negedge clk);
        chk("ovf_err_sticky", 64'(order_err), 64'd1);

        // Reset while waiting on the engine, then stray done
        reset = 1'b0;
        @(negedge clk);
        reset      = 1'b1;
        snoop_only = 1'b0;
        b_start    = n_start;
        push_load(10'h010);
        i = 0;
        while (n_start == b_start && i < 100) begin
            @(negedge clk);
            i++;
        end
        chk("mid_load_started", 64'(n_start - b_start), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_busy", 64'(sched_busy), 64'd0);
        chk("mid_done", 64'(data_mem_decrypt_done), 64'd0);
        chk("mid_rd_data", rd_data, 64'd0);
        chk("mid_dmem_en", 64'(dmem_en), 64'd0);
        chk("mid_bf_start", 64'(bf_start), 64'd0);
        chk("mid_q_empty", 64'(dut.u_order_q.empty), 64'd1);
        @(negedge clk);
        reset  = 1'b1;
        b_done = n_done_rise;
        repeat (4) @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_no_done_pulse", 64'(n_done_rise - b_done), 64'd0);
        chk("mid_idle", 64'(sched_busy), 64'd0);
        chk("mid_rd_data_after", rd_data, 64'd0);
        chk("mid_q_empty_after", 64'(dut.u_order_q.empty), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_scheduler.md
Name: data_mem_scheduler

Overview:
- Sequences the single shared data-side Blowfish engine and the data memory for queued memory-write (MWR) and memory-read (MRR) requests.
- Stores: the block pops plaintext and address, encrypts the data, then writes the ciphertext to memory.
- Loads: the block pops the address, reads memory, decrypts, then holds the plaintext with data_mem_decrypt_done until the core controller consumes it.
- Requests are served strictly in program order, recorded by snooping the FIFO write enables.

Parameters:
- ADDR_W, 10, data memory word-address width.
- DATA_W, 64, data word and Blowfish block width.
- ORDER_DEPTH, 16, depth of the request-order queue; must equal the MWR/MRR FIFO depth.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- MWR_fifo_wr_en  in  1  snoop: store enqueued.
- MRR_fifo_wr_en  in  1  snoop: load enqueued.
- mwr_fifo_empty  in  1  MWR data/addr FIFOs empty.
- mwr_fifo_dout  in  DATA_W  store plaintext.
- mwr_addr_fifo_dout  in  ADDR_W  store address.
- mwr_fifo_rd_en  out  1  pops MWR data and addr FIFOs together.
- mrr_fifo_empty  in  1  MRR FIFO empty.
- mrr_fifo_dout  in  ADDR_W  load address.
- mrr_fifo_rd_en  out  1  pops MRR FIFO.
- bf_start  out  1  one-cycle start pulse to Blowfish.
- bf_mode  out  1  0 = encrypt, 1 = decrypt.
- bf_din  out  DATA_W  Blowfish input block.
- bf_busy  in  1  engine busy.
- bf_done  in  1  one-cycle done pulse.
- bf_dout  in  DATA_W  engine result.
- dmem_en  out  1  memory enable.
- dmem_we  out  1  memory write enable.
- dmem_addr  out  ADDR_W  memory address.
- dmem_wdata  out  DATA_W  ciphertext to memory.
- dmem_rdata  in  DATA_W  memory read data; 1-cycle latency.
- data_mem_decrypt_done  out  1  level: plaintext ready on rd_data.
- rd_data  out  DATA_W  decrypted load data.
- decrypt_ack  in  1  controller consumed rd_data (driven by reg_dest_fifo_rd_en).
- sched_busy  out  1  state != S_IDLE.
- order_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (reset=0, async): state S_IDLE, order queue empty; every output and data register 0, including rd_data and order_err. Any in-flight Blowfish operation is abandoned; a bf_done that arrives afterwards in S_IDLE is ignored.
- FIFOs are standard mode: dout is valid the cycle after rd_en.
- Order queue: each entry is 1 bit (0 = store, 1 = load).
  - A push happens on MWR_fifo_wr_en or MRR_fifo_wr_en.
  - Both enables in the same cycle: push a store only and set order_err.
  - Push while full: drop the entry and set order_err.
  - Pop happens on the grant cycle. Simultaneous push and pop is legal; occupancy is unchanged.
- S_IDLE grant: when the queue is non-empty, inspect the head entry.
  - Head = 0 and !mwr_fifo_empty: pulse mwr_fifo_rd_en, pop the queue, go to S_W_POP.
  - Head = 1 and !mrr_fifo_empty: pulse mrr_fifo_rd_en, pop the queue, go to S_R_POP.
  - Otherwise stay in S_IDLE. This covers FIFO empty-flag lag; there is no reordering and no bypass.
- Store path:
  - S_W_POP: capture data and addr, go to S_W_ENC.
  - S_W_ENC: if !bf_busy, pulse bf_start with bf_mode=0 and bf_din=data, go to S_W_WAIT; else hold.
  - S_W_WAIT: on bf_done, capture bf_dout, go to S_W_MEM.
  - S_W_MEM: dmem_en=1, dmem_we=1 for one cycle, go to S_IDLE.
  - Minimum store latency from grant to memory write: 4 cycles plus Blowfish latency.
- Load path:
  - S_R_POP: capture addr, go to S_R_MEM.
  - S_R_MEM: dmem_en=1, dmem_we=0, go to S_R_DATA.
  - S_R_DATA: capture dmem_rdata, go to S_R_DEC.
  - S_R_DEC: if !bf_busy, pulse bf_start with bf_mode=1, go to S_R_WAIT; else hold.
  - S_R_WAIT: on bf_done, load rd_data, go to S_R_HOLD.
  - S_R_HOLD: data_mem_decrypt_done=1 held until decrypt_ack. On decrypt_ack, deassert done in the same cycle's next edge and go to S_IDLE. rd_data is held until the next load completes.
- Outputs are registered or decoded from state only. bf_start, dmem_en, mwr_fifo_rd_en and mrr_fifo_rd_en are single-cycle pulses.
- bf_done outside S_W_WAIT and S_R_WAIT is ignored. decrypt_ack outside S_R_HOLD is ignored.
- At most one request is in flight; no new grant is issued until the current request returns to S_IDLE.

Decomposition:
- Package data_sched_pkg holds:
  - the state encoding (4-bit);
  - BF_ENCRYPT=1'b0 and BF_DECRYPT=1'b1;
  - REQ_STORE=1'b0 and REQ_LOAD=1'b1.
- Sub-module req_order_queue: a 1-bit wide, ORDER_DEPTH-deep circular FIFO.
  - Uses clog2(ORDER_DEPTH)+1-bit read/write pointers.
  - Provides push, pop, head, empty, full and overflow outputs.

Test Plan:
- Single store: enqueue data=64'h0123456789ABCDEF, addr=10'h005; Blowfish model with 3-cycle latency -> exactly one dmem write to 0x005 with the model's ciphertext; mwr_fifo_rd_en pulses once; sched_busy low afterwards.
- Single load: mem[0x005] preloaded with ciphertext; enqueue a load of 0x005 -> data_mem_decrypt_done rises holding 64'h0123456789ABCDEF. Hold decrypt_ack low for 5 cycles: done stays high. On ack, done falls and state returns to S_IDLE.
- Ordering: enqueue store(0x010, A), load(0x010), store(0x010, B), load(0x010) -> loads return A then B; memory access order is W, R, W, R.
- Engine busy: hold bf_busy=1 for 6 cycles at S_W_ENC -> bf_start is withheld until busy falls, then pulses exactly once.
- Errors: assert both FIFO wr_en in the same cycle, then issue 17 pushes with ORDER_DEPTH=16 -> order_err set and sticky; queue occupancy is 16.
- Reset mid-operation: assert reset in S_R_WAIT, release it, then send a stray bf_done -> all outputs 0, no done pulse, queue empty.
